// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard event pacer.
package kbd_pkg;

  // Bit positions inside the 11-bit ps2_key bus.
  localparam int PS2_TGL   = 10;
  localparam int PS2_PRESS = 9;
  localparam int PS2_EXT   = 8;

  // One buffered key event (the toggle bit is not stored).
  typedef struct packed {
    logic       ext;
    logic       press;
    logic [7:0] code;
  } kbd_evt_t;

  // Pacer state, also exported on the debug port.
  typedef enum logic {
    PACE_IDLE = 1'b0,
    PACE_HOLD = 1'b1
  } pace_state_t;

  // Extract an event from ps2_key[9:0].
  function automatic kbd_evt_t evt_from_ps2(input logic [9:0] k);
    kbd_evt_t e;
    e.ext   = k[PS2_EXT];
    e.press = k[PS2_PRESS];
    e.code  = k[7:0];
    return e;
  endfunction

  // Rebuild ps2_key[9:0] from a stored event.
  function automatic logic [9:0] evt_to_ps2(input kbd_evt_t e);
    return {e.press, e.ext, e.code};
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Synchronous FIFO of key events with occupancy count and reset flush.
//
// Handshake: push_i is accepted on a clock edge when the FIFO is not full,
// or when it is full and a pop is accepted on the same edge. pop_i is
// accepted only when the FIFO is not empty; pop_data_o is valid whenever
// empty_o is low and shows the oldest entry. A rejected push is simply lost.
module kbd_event_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  kbd_evt_t                     push_data_i,
  input  logic                         pop_i,
  output kbd_evt_t                     pop_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  kbd_evt_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q,  level_d;
  logic            do_push, do_pop;

  assign full_o     = (level_q == LW'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state for pointers and occupancy; pointers wrap since DEPTH is 2^n.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer/occupancy registers; reset flushes the contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/kbd_event_pacer.sv
// Buffers PS/2 make/break events and replays them on a ps2_key-format bus,
// holding each one for MIN_SCANS CPU matrix scans (or TIMEOUT cycles).
module kbd_event_pacer
  import kbd_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int MIN_SCANS = 2,
  parameter int TIMEOUT   = 262144
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [10:0]                  ps2_key,
  input  logic                         scan_strobe,
  output logic [10:0]                  ps2_key_out,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         overflow,
  output pace_state_t                  dbg_state
);

  localparam int SW = $clog2(MIN_SCANS+1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] SCAN_MAX = SW'(MIN_SCANS);
  localparam logic [TW-1:0] TIME_MAX = TW'(TIMEOUT-1);

  logic            old_tgl_q;
  logic            push;
  logic            pop;
  logic            fifo_full, fifo_empty;
  kbd_evt_t        fifo_head;
  pace_state_t     state_q;
  logic [9:0]      out_data_q;
  // Not reset: a reset-driven flip would look like a new event downstream.
  logic            out_tgl_q = 1'b0;
  logic [SW-1:0]   scan_cnt_q;
  logic [TW-1:0]   timer_q;
  logic            overflow_q;
  logic            scan_inc, scan_done, timer_done;

  // Toggle tracker; also loads during reset so no phantom event follows it.
  always_ff @(posedge clk_sys) begin
    old_tgl_q <= ps2_key[PS2_TGL];
  end

  assign push = !reset && (old_tgl_q != ps2_key[PS2_TGL]);
  assign pop  = (state_q == PACE_IDLE) && !fifo_empty;

  kbd_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_sys),
    .rst_i       (reset),
    .push_i      (push),
    .push_data_i (evt_from_ps2(ps2_key[9:0])),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  assign scan_inc   = scan_strobe && (scan_cnt_q != SCAN_MAX);
  assign scan_done  = scan_inc && (scan_cnt_q == SCAN_MAX - 1'b1);
  assign timer_done = (timer_q == TIME_MAX);

  // Pacing FSM: issue the FIFO head, then hold until enough scans or timeout.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= PACE_IDLE;
      out_data_q <= '0;
      scan_cnt_q <= '0;
      timer_q    <= '0;
    end else begin
      case (state_q)
        PACE_IDLE: begin
          if (!fifo_empty) begin
            out_data_q <= evt_to_ps2(fifo_head);
            out_tgl_q  <= ~out_tgl_q;
            scan_cnt_q <= '0;
            timer_q    <= '0;
            state_q    <= PACE_HOLD;
          end
        end
        PACE_HOLD: begin
          if (scan_inc)    scan_cnt_q <= scan_cnt_q + 1'b1;
          if (!timer_done) timer_q    <= timer_q + 1'b1;
          if (scan_done || timer_done) state_q <= PACE_IDLE;
        end
        default: state_q <= PACE_IDLE;
      endcase
    end
  end

  // Sticky drop flag: a push met a full FIFO with nothing leaving.
  always_ff @(posedge clk_sys) begin
    if (reset)                              overflow_q <= 1'b0;
    else if (push && fifo_full && !pop)     overflow_q <= 1'b1;
  end

  assign ps2_key_out = {out_tgl_q, out_data_q};
  assign busy        = (state_q == PACE_HOLD) | (fifo_level != '0);
  assign overflow    = overflow_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_kbd_event_pacer.sv
// Directed bench for kbd_event_pacer with a queue-based event scoreboard.
module tb_kbd_event_pacer;
  import kbd_pkg::*;

  localparam int DEPTH     = 8;
  localparam int MIN_SCANS = 2;
  localparam int TIMEOUT   = 16;
  localparam int GAP       = TIMEOUT + 1;

  // ---------------- clock / reset ----------------
  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [10:0] ps2_key = '0;
  logic        scan_strobe = 1'b0;
  logic [10:0] ps2_key_out;
  logic        busy;
  logic [3:0]  fifo_level;
  logic        overflow;
  pace_state_t dbg_state;

  always #5 clk_sys = ~clk_sys;

  kbd_event_pacer #(.DEPTH(DEPTH), .MIN_SCANS(MIN_SCANS), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_key     (ps2_key),
    .scan_strobe (scan_strobe),
    .ps2_key_out (ps2_key_out),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [9:0] exp_q[$];
  logic       exp_tgl = 1'b0;
  int         cyc = 0;
  int         chk_gap = 0;
  bit         gap_first = 1'b0;
  logic [7:0] codes [0:9];

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe();
    scan_strobe = 1'b1;
    tick(1);
    scan_strobe = 1'b0;
  endtask

  task automatic send(input logic press, input logic ext, input logic [7:0] code, input bit will_issue);
    ps2_key = {~ps2_key[10], press, ext, code};
    if (will_issue) begin
      exp_q.push_back({press, ext, code});
      exp_tgl = ~exp_tgl;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    while (busy && k < max_cyc) begin
      tick(1);
      k++;
    end
    check("idle_timeout", busy, 0);
    tick(1);
    check("queue_drained", exp_q.size(), 0);
    check("tgl_parity", ps2_key_out[10], exp_tgl);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic       prev_tgl;
    logic [9:0] prev_data;
    logic [9:0] e;
    int         last_issue;
    @(negedge clk_sys);
    prev_tgl   = ps2_key_out[10];
    prev_data  = ps2_key_out[9:0];
    last_issue = 0;
    forever begin
      @(negedge clk_sys);
      if (ps2_key_out[10] !== prev_tgl) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_event: got 0x%0h, expected no event", ps2_key_out[9:0]);
        end else begin
          e = exp_q.pop_front();
          check("issue_data", ps2_key_out[9:0], e);
        end
        if (chk_gap != 0) begin
          if (gap_first) gap_first = 1'b0;
          else check("issue_gap", cyc - last_issue, chk_gap);
        end
        last_issue = cyc;
      end else if (!reset && ps2_key_out[9:0] !== prev_data) begin
        n_vec++;
        n_err++;
        $display("FAIL silent_change: got 0x%0h, expected 0x%0h", ps2_key_out[9:0], prev_data);
      end
      prev_tgl  = ps2_key_out[10];
      prev_data = ps2_key_out[9:0];
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    codes[0] = 8'h1c; codes[1] = 8'h32; codes[2] = 8'h21; codes[3] = 8'h23; codes[4] = 8'h24;
    codes[5] = 8'h2b; codes[6] = 8'h34; codes[7] = 8'h33; codes[8] = 8'h43; codes[9] = 8'h3b;

    // Reset state
    tick(3);
    check("rst_out", ps2_key_out, 11'h000);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_state", dbg_state, PACE_IDLE);
    reset = 1'b0;
    tick(1);
    check("post_rst_level", fifo_level, 0);

    // Single tap: press, release 3 cycles later, 2 strobes per event
    send(1'b1, 1'b0, 8'h1c, 1'b1);
    tick(1);
    check("tap_lat1_out", ps2_key_out, 11'h000);
    check("tap_lat1_level", fifo_level, 1);
    tick(1);
    check("tap_press_out", ps2_key_out, 11'h61c);
    check("tap_press_state", dbg_state, PACE_HOLD);
    tick(1);
    send(1'b0, 1'b0, 8'h1c, 1'b1);
    tick(1);
    check("tap_rel_queued", fifo_level, 1);
    strobe();
    tick(2);
    check("tap_hold_1strobe", ps2_key_out, 11'h61c);
    strobe();
    check("tap_hold_exit_out", ps2_key_out, 11'h61c);
    check("tap_hold_exit_state", dbg_state, PACE_IDLE);
    tick(1);
    check("tap_release_out", ps2_key_out, 11'h01c);
    strobe();
    tick(1);
    strobe();
    wait_idle(50);

    // Burst of 8, no strobes: paced by timeout, in order
    chk_gap = GAP; gap_first = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 1'b0, codes[i], 1'b1);
      tick(1);
    end
    check("burst8_peak_level", fifo_level, 7);
    check("burst8_ovf", overflow, 0);
    wait_idle(400);
    check("burst8_ovf_end", overflow, 0);

    // Overflow: blocker in HOLD, 9 events -> 9th dropped, 10th after a pop
    gap_first = 1'b1;
    send(1'b1, 1'b0, 8'h76, 1'b1);
    tick(2);
    for (int i = 0; i < 9; i++) begin
      send(1'b1, 1'b0, codes[i], (i != 8));
      tick(1);
    end
    check("ovf_level_full", fifo_level, 8);
    check("ovf_flag", overflow, 1);
    begin
      int k = 0;
      while (fifo_level == 4'd8 && k < 100) begin
        tick(1);
        k++;
      end
    end
    check("ovf_level_after_pop", fifo_level, 7);
    send(1'b1, 1'b0, codes[9], 1'b1);
    wait_idle(400);
    check("ovf_sticky", overflow, 1);
    chk_gap = 0;

    do_reset();
    check("ovf_cleared_by_reset", overflow, 0);

    // Full FIFO: push on the same edge as the HOLD->IDLE pop
    chk_gap = GAP; gap_first = 1'b1;
    send(1'b0, 1'b1, 8'h75, 1'b1);
    tick(2);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 1'b0, codes[i], 1'b1);
      tick(1);
    end
    check("full_level", fifo_level, 8);
    begin
      int k = 0;
      while (dbg_state != PACE_IDLE && k < 100) begin
        tick(1);
        k++;
      end
    end
    check("full_hold_exit", dbg_state, PACE_IDLE);
    send(1'b0, 1'b0, 8'h5a, 1'b1);
    tick(1);
    check("poppush_level", fifo_level, 8);
    check("poppush_ovf", overflow, 0);
    wait_idle(400);
    chk_gap = 0;

    // Reset mid-HOLD with 3 queued
    send(1'b1, 1'b1, 8'h6b, 1'b1);
    tick(2);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 1'b0, codes[i], 1'b0);
      tick(1);
    end
    check("midhold_level", fifo_level, 3);
    reset = 1'b1;
    tick(1);
    check("midhold_rst_level", fifo_level, 0);
    check("midhold_rst_busy", busy, 0);
    check("midhold_rst_data", ps2_key_out[9:0], 10'h000);
    check("midhold_rst_tgl", ps2_key_out[10], exp_tgl);
    check("midhold_rst_state", dbg_state, PACE_IDLE);
    tick(1);
    reset = 1'b0;
    tick(40);
    check("after_rst_level", fifo_level, 0);
    check("after_rst_busy", busy, 0);
    check("after_rst_queue", exp_q.size(), 0);

    // Strobes in IDLE do not count toward the next hold
    strobe(); tick(1); strobe(); tick(1); strobe(); tick(2);
    send(1'b1, 1'b0, 8'h1b, 1'b1);
    tick(1);
    send(1'b1, 1'b0, 8'h4d, 1'b1);
    tick(1);
    check("idle_strobe_a", ps2_key_out[9:0], 10'h21b);
    check("idle_strobe_level", fifo_level, 1);
    strobe();
    tick(2);
    check("idle_strobe_hold1", ps2_key_out[9:0], 10'h21b);
    check("idle_strobe_state", dbg_state, PACE_HOLD);
    strobe();
    check("idle_strobe_hold2", ps2_key_out[9:0], 10'h21b);
    tick(1);
    check("idle_strobe_b", ps2_key_out[9:0], 10'h24d);
    strobe();
    tick(1);
    strobe();
    wait_idle(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
